// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: scan-out stage between a synchronous-read framebuffer RAM and the VGA pins.
//
// Generates 640x480@60 timing from the system clock using a pixel-clock-enable divider. It
// fetches one framebuffer word per screen pixel, replicating each framebuffer pixel SCALE times
// in both axes. It registers RGB and both syncs on the slot tick, so every pin lags its counter
// slot by exactly one slot.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-high reset
//   ram_rd_en    one-clock read strobe, in the div == 0 clock of each active slot
//   ram_addr     framebuffer read address (holds its last value between strobes)
//   ram_data     pixel {R,G,B}, valid RD_LAT clocks after ram_rd_en
//   red/green/blue  VGA colour, forced to 0 during blanking
//   hsync/vsync  active-low syncs
//   frame_start  one-clock pulse when pixel (0,0) reaches the pins

module vga_fb_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIX_DIV  = 4,
    parameter int unsigned SCALE    = 4,
    parameter int unsigned FB_W     = 160,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [11:0]       ram_data,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW      = $clog2(PIX_DIV);
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned FXW     = (FB_W > 1) ? $clog2(FB_W) : 1;
    localparam int unsigned SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    logic [DW-1:0]     div_q, div_d;
    logic [HW-1:0]     hc_q, hc_d;
    logic [VW-1:0]     vc_q, vc_d;
    logic [FXW-1:0]    fx_q, fx_d;
    logic [SW-1:0]     sx_q, sx_d;
    logic [SW-1:0]     sy_q, sy_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q;
    logic [11:0]       pix_q;
    logic [11:0]       pix_now;
    logic [11:0]       rgb_q;
    logic              hsync_q, vsync_q, frame_start_q;

    logic tick, active, capture, hc_end, vc_end, line_end, in_hsync, in_vsync;

    always_comb begin
        tick     = (div_q == DW'(PIX_DIV - 1));
        capture  = (div_q == DW'(RD_LAT));
        active   = (hc_q < HW'(H_ACTIVE)) && (vc_q < VW'(V_ACTIVE));
        hc_end   = (hc_q == HW'(H_TOTAL - 1));
        vc_end   = (vc_q == VW'(V_TOTAL - 1));
        line_end = (hc_q == HW'(H_ACTIVE - 1));
        in_hsync = (hc_q >= HW'(H_ACTIVE + H_FP)) && (hc_q < HW'(H_ACTIVE + H_FP + H_SYNC));
        in_vsync = (vc_q >= VW'(V_ACTIVE + V_FP)) && (vc_q < VW'(V_ACTIVE + V_FP + V_SYNC));

        // With RD_LAT == PIX_DIV-1 the data lands on the tick edge itself, so bypass pix_q.
        pix_now  = capture ? ram_data : pix_q;

        div_d      = tick ? '0 : div_q + DW'(1);
        hc_d       = hc_q;
        vc_d       = vc_q;
        fx_d       = fx_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        row_base_d = row_base_q;

        if (tick) begin
            hc_d = hc_end ? '0 : hc_q + HW'(1);
            if (hc_end) begin
                vc_d = vc_end ? '0 : vc_q + VW'(1);
            end

            if (active) begin
                if (line_end) begin
                    fx_d = '0;
                    sx_d = '0;
                end else if (sx_q == SW'(SCALE - 1)) begin
                    sx_d = '0;
                    fx_d = fx_q + FXW'(1);
                end else begin
                    sx_d = sx_q + SW'(1);
                end
            end

            // Row base advances by one framebuffer row every SCALE screen lines.
            if (hc_end && (vc_q < VW'(V_ACTIVE))) begin
                if (sy_q == SW'(SCALE - 1)) begin
                    sy_d       = '0;
                    row_base_d = row_base_q + ADDR_W'(FB_W);
                end else begin
                    sy_d = sy_q + SW'(1);
                end
            end

            if (hc_end && vc_end) begin
                row_base_d = '0;
                sy_d       = '0;
            end
        end
    end

    // Strobe is combinational so the first read goes out in the very first clock after reset;
    // gating with reset keeps it low while the counters sit at (0,0).
    assign ram_rd_en = !reset && (div_q == '0) && active;
    assign ram_addr  = ram_rd_en ? (row_base_q + ADDR_W'(fx_q)) : addr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            hc_q          <= '0;
            vc_q          <= '0;
            fx_q          <= '0;
            sx_q          <= '0;
            sy_q          <= '0;
            row_base_q    <= '0;
            addr_q        <= '0;
            pix_q         <= '0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            fx_q          <= fx_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            row_base_q    <= row_base_d;
            addr_q        <= ram_addr;
            frame_start_q <= tick && (hc_q == '0) && (vc_q == '0);
            if (capture) begin
                pix_q <= ram_data;
            end
            if (tick) begin
                rgb_q   <= active ? pix_now : 12'h000;
                hsync_q <= !in_hsync;
                vsync_q <= !in_vsync;
            end
        end
    end

    assign red         = rgb_q[11:8];
    assign green       = rgb_q[7:4];
    assign blue        = rgb_q[3:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: one full-size instance (640x480, RD_LAT=1) for line-level timing,
// addressing, pixel and reset checks, plus a shrunken instance (16x8 active, RD_LAT=3) so
// frame-level behaviour fits in a short run.

module tb_vga_fb_scanout;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fff   = 1'b0;

    // Full-size instance
    logic        ram_rd_en;
    logic [14:0] ram_addr;
    logic [11:0] ram_data, ram_q;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync, frame_start;

    // Small instance
    logic        s_rd_en;
    logic [3:0]  s_addr;
    logic [11:0] s_data, s_p1, s_p2, s_p3;
    logic [3:0]  s_red, s_green, s_blue;
    logic        s_hsync, s_vsync, s_fs;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    vga_fb_scanout dut (
        .clock       (clock),
        .reset       (reset),
        .ram_rd_en   (ram_rd_en),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    vga_fb_scanout #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (1),
        .PIX_DIV  (4),  .SCALE (4), .FB_W (4), .ADDR_W (4), .RD_LAT (3)
    ) dut_s (
        .clock       (clock),
        .reset       (reset),
        .ram_rd_en   (s_rd_en),
        .ram_addr    (s_addr),
        .ram_data    (s_data),
        .red         (s_red),
        .green       (s_green),
        .blue        (s_blue),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .frame_start (s_fs)
    );

    // RAM models: data = low 12 address bits, latency 1 and 3 clocks.
    initial begin
        ram_q = '0; s_p1 = '0; s_p2 = '0; s_p3 = '0;
    end
    always @(posedge clock) begin
        if (ram_rd_en) ram_q <= 12'(ram_addr);
        if (s_rd_en) s_p1 <= 12'(s_addr);
        s_p2 <= s_p1;
        s_p3 <= s_p2;
    end
    assign ram_data = fff ? 12'hFFF : ram_q;
    assign s_data   = s_p3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, 32'({red, green, blue}), 32'h0);
        check({tag, "_hsync"}, 32'(hsync), 32'h1);
        check({tag, "_vsync"}, 32'(vsync), 32'h1);
        check({tag, "_rd_en"}, 32'(ram_rd_en), 32'h0);
        check({tag, "_addr"}, 32'(ram_addr), 32'h0);
        check({tag, "_fs"}, 32'(frame_start), 32'h0);
    endtask

    initial begin
        int fs_first, fs_count, rd_idx, hs_low, nfall, nz5, fff5;
        int hfall [2];
        logic hs_prev;
        logic [14:0] a0_first, a0_5th, a0_last, a1_first, a4_first;
        logic [11:0] rgb, rgb5, rgb21, rgb37, rgb_l4;
        int s_fs_t [2];
        int s_nfs, s_vs_low, s_hs_low, s_rd;
        logic [3:0] s_last, s_f1, s_l4;
        logic [11:0] s_rgb21, s_rgb389;

        fs_first = -1; fs_count = 0; rd_idx = 0; hs_low = 0; nfall = 0; nz5 = 0; fff5 = 0;
        hfall[0] = -1; hfall[1] = -1; hs_prev = 1'b1;
        a0_first = '1; a0_5th = '1; a0_last = '1; a1_first = '1; a4_first = '1;
        rgb5 = 'x; rgb21 = 'x; rgb37 = 'x; rgb_l4 = 'x;

        // Reset held 10 clocks
        repeat (10) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("in_reset");
        reset = 1'b0;
        #1;

        // Phase A: six lines from release, k = clock index after release
        for (int k = 0; k < 19200; k++) begin
            if (k > 0) begin
                @(negedge clock);
                #1;
            end
            rgb = {red, green, blue};
            if (k == 0) begin
                check("first_rd_en", 32'(ram_rd_en), 32'h1);
                check("first_addr", 32'(ram_addr), 32'h0);
            end
            if (k == 15500) fff = 1'b1;
            if (frame_start) begin
                fs_count++;
                if (fs_first < 0) fs_first = k;
            end
            if (k < 3200) begin
                if (ram_rd_en) begin
                    if (rd_idx == 0) a0_first = ram_addr;
                    if (rd_idx == 4) a0_5th = ram_addr;
                    a0_last = ram_addr;
                    rd_idx++;
                end
                if (!hsync) hs_low++;
            end
            if (k == 3200 && ram_rd_en) a1_first = ram_addr;
            if (k == 12800 && ram_rd_en) a4_first = ram_addr;
            if (hs_prev && !hsync && nfall < 2) begin
                hfall[nfall] = k;
                nfall++;
            end
            hs_prev = hsync;
            if (k == 5) rgb5 = rgb;
            if (k == 21) rgb21 = rgb;
            if (k == 37) rgb37 = rgb;
            if (k == 12805) rgb_l4 = rgb;
            if (k >= 16000) begin
                if (rgb != 12'h000) nz5++;
                if (rgb == 12'hFFF) fff5++;
            end
        end

        check("frame_start_delay", 32'(fs_first), 32'd4);
        check("frame_start_pulses", 32'(fs_count), 32'd1);
        check("rd_per_line", 32'(rd_idx), 32'd640);
        check("line0_addr_first", 32'(a0_first), 32'd0);
        check("line0_addr_5th", 32'(a0_5th), 32'd1);
        check("line0_addr_last", 32'(a0_last), 32'd159);
        check("line1_addr_first", 32'(a1_first), 32'd0);
        check("line4_addr_first", 32'(a4_first), 32'd160);
        check("hsync_low_clocks", 32'(hs_low), 32'd384);
        check("hsync_first_fall", 32'(hfall[0]), 32'd2628);
        check("hsync_period", 32'(hfall[1] - hfall[0]), 32'd3200);
        check("rgb_x0_y0", 32'(rgb5), 32'h000);
        check("rgb_x4_y0", 32'(rgb21), 32'h001);
        check("rgb_x8_y0", 32'(rgb37), 32'h002);
        check("rgb_x0_y4", 32'(rgb_l4), 32'h0A0);
        check("blank_nonzero", 32'(nz5), 32'd2560);
        check("blank_fff", 32'(fff5), 32'd2560);

        // Phase B: reset mid-line 6 (hc = 250, read strobe active, RGB = FFF)
        repeat (1001) @(negedge clock);
        #1;
        check("pre_reset_rd_en", 32'(ram_rd_en), 32'h1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midline_reset");
        repeat (3) @(negedge clock);
        check_reset_outputs("midline_hold");
        fff = 1'b0;
        reset = 1'b0;
        #1;

        nfall = 0; hfall[0] = -1; hs_prev = 1'b1; rd_idx = 0; rgb21 = 'x; a0_5th = '1;
        s_fs_t[0] = -1; s_fs_t[1] = -1; s_nfs = 0; s_vs_low = 0; s_hs_low = 0; s_rd = 0;
        s_last = '1; s_f1 = '1; s_l4 = '1; s_rgb21 = 'x; s_rgb389 = 'x;

        for (int k = 0; k < 3200; k++) begin
            if (k > 0) begin
                @(negedge clock);
                #1;
            end
            if (k == 0) begin
                check("restart_rd_en", 32'(ram_rd_en), 32'h1);
                check("restart_addr", 32'(ram_addr), 32'h0);
            end
            if (ram_rd_en) begin
                if (rd_idx == 4) a0_5th = ram_addr;
                rd_idx++;
            end
            if (hs_prev && !hsync && nfall == 0) begin
                hfall[0] = k;
                nfall++;
            end
            hs_prev = hsync;
            if (k == 21) rgb21 = {red, green, blue};

            if (s_fs && s_nfs < 2) begin
                s_fs_t[s_nfs] = k;
                s_nfs++;
            end
            if (k < 1152) begin
                if (!s_vsync) s_vs_low++;
                if (s_rd_en) begin
                    s_rd++;
                    s_last = s_addr;
                end
            end
            if (k < 96 && !s_hsync) s_hs_low++;
            if (k == 1152 && s_rd_en) s_f1 = s_addr;
            if (k == 384 && s_rd_en) s_l4 = s_addr;
            if (k == 21) s_rgb21 = {s_red, s_green, s_blue};
            if (k == 389) s_rgb389 = {s_red, s_green, s_blue};
        end

        check("restart_rd_per_line", 32'(rd_idx), 32'd640);
        check("restart_addr_5th", 32'(a0_5th), 32'd1);
        check("restart_hsync_fall", 32'(hfall[0]), 32'd2628);
        check("restart_rgb_x4", 32'(rgb21), 32'h001);

        check("s_frame_start_first", 32'(s_fs_t[0]), 32'd4);
        check("s_frame_period", 32'(s_fs_t[1] - s_fs_t[0]), 32'd1152);
        check("s_vsync_low_clocks", 32'(s_vs_low), 32'd192);
        check("s_hsync_low_clocks", 32'(s_hs_low), 32'd16);
        check("s_rd_per_frame", 32'(s_rd), 32'd128);
        check("s_last_addr", 32'(s_last), 32'd7);
        check("s_next_frame_addr", 32'(s_f1), 32'd0);
        check("s_line4_addr", 32'(s_l4), 32'd4);
        check("s_rgb_x4_lat3", 32'(s_rgb21), 32'h001);
        check("s_rgb_x0_y4_lat3", 32'(s_rgb389), 32'h004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
